vote_tally: RTL and testbench

- Downstream consumer of the vote counter stage; accumulates its one-hot per-round vote count over a fixed number of voting rounds.
- Produces the session yes-vote total, the number of unanimous rounds, and a final majority/tie verdict.
- Sits between the combinational vote counter and the result display/report logic.

---
 rtl/vote_tally.sv | 111 +++++++++++
 tb/tb_vote_tally.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// ============================================================================
// Module   : vote_tally
// Function : Session accumulator for one-hot vote counts: yes total,
//            unanimous-round count and final majority/tie verdict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vote_tally #(
   parameter int ROUNDS = 8,
   parameter int CNT_W  = 6,
   parameter int RND_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             count_valid,
   input  logic [4:0]       count_onehot,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] yes_total,
   output logic [RND_W-1:0] rounds_seen,
   output logic [RND_W-1:0] unanimous,
   output logic             majority,
   output logic             tie,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);
   localparam logic [CNT_W:0]   THREE_R  = (CNT_W+1)'(3 * ROUNDS);

   state_t     state, next_state;
   logic       clear, accept, flag_err;
   logic       legal;
   logic [1:0] vote;
   logic [CNT_W:0] twice_yes;

   assign legal = ~count_onehot[4] & $onehot(count_onehot[3:0]);
   // Only meaningful for legal one-hot codes: bit3->3, bit2->2, bit1->1, bit0->0.
   assign vote  = {count_onehot[3] | count_onehot[2], count_onehot[3] | count_onehot[1]};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      clear      = 1'b0;
      accept     = 1'b0;
      flag_err   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               clear      = 1'b1;
               next_state = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (start) begin
               clear = 1'b1;
            end else if (count_valid) begin
               if (legal) begin
                  accept = 1'b1;
                  if (rounds_seen == LAST_RND) next_state = S_DONE;
               end else begin
                  flag_err = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               clear      = 1'b1;
               next_state = S_COLLECT;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         yes_total   <= '0;
         rounds_seen <= '0;
         unanimous   <= '0;
         err         <= 1'b0;
      end else begin
         if (accept) begin
            yes_total   <= yes_total + CNT_W'(vote);
            rounds_seen <= rounds_seen + RND_W'(1);
            if (vote == 2'd0 || vote == 2'd3) unanimous <= unanimous + RND_W'(1);
         end
         if (flag_err) err <= 1'b1;
      end
   end

   assign busy      = (state == S_COLLECT);
   assign done      = (state == S_DONE);
   assign twice_yes = {yes_total, 1'b0};
   assign majority  = done && (twice_yes > THREE_R);
   assign tie       = done && (twice_yes == THREE_R);

endmodule

`default_nettype wire

// File: tb/tb_vote_tally.sv
// Directed testbench for vote_tally (ROUNDS=8): each task drives a scenario
// and compares the packed output vector against hand-computed values.
`default_nettype none

module tb_vote_tally;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       count_valid = 1'b0;
   logic [4:0] count_onehot = 5'd0;
   logic       busy, done, majority, tie, err;
   logic [5:0] yes_total;
   logic [3:0] rounds_seen, unanimous;

   int total = 0;
   int bad   = 0;

   // {busy, done, yes_total, rounds_seen, unanimous, majority, tie, err}
   logic [18:0] obs;
   assign obs = {busy, done, yes_total, rounds_seen, unanimous, majority, tie, err};

   vote_tally #(.ROUNDS(8), .CNT_W(6), .RND_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .count_valid(count_valid),
      .count_onehot(count_onehot), .busy(busy), .done(done),
      .yes_total(yes_total), .rounds_seen(rounds_seen), .unanimous(unanimous),
      .majority(majority), .tie(tie), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [4:0] v);
      count_valid  = 1'b1;
      count_onehot = v;
      tick();
      count_valid  = 1'b0;
      count_onehot = 5'd0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b0;
      total++;
      if (obs !== 19'd0) begin
         bad++; $display("FAIL reset_state act=%h req=%h", obs, 19'd0);
      end
      count_valid  = 1'b1;
      count_onehot = 5'b01000;
      tick(); tick();
      count_valid = 1'b0;
      total++;
      if (obs !== 19'd0) begin
         bad++; $display("FAIL idle_ignores_beat act=%h req=%h", obs, 19'd0);
      end
   endtask

   task automatic test_low_session();
      do_start();
      total++;
      if (obs !== {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000}) begin
         bad++; $display("FAIL low_after_start act=%h req=%h", obs, {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000});
      end
      for (int i = 0; i < 8; i++) begin
         beat(5'b00010);
         if (i < 7) begin
            total++;
            if (obs !== {1'b1, 1'b0, 6'(i + 1), 4'(i + 1), 4'd0, 3'b000}) begin
               bad++; $display("FAIL low_beat%0d act=%h req=%h", i, obs, {1'b1, 1'b0, 6'(i + 1), 4'(i + 1), 4'd0, 3'b000});
            end
         end
      end
      total++;
      if (obs !== {1'b0, 1'b1, 6'd8, 4'd8, 4'd0, 3'b000}) begin
         bad++; $display("FAIL low_final act=%h req=%h", obs, {1'b0, 1'b1, 6'd8, 4'd8, 4'd0, 3'b000});
      end
   endtask

   task automatic test_unanimous_yes();
      do_start();
      for (int i = 0; i < 8; i++) beat(5'b01000);
      total++;
      if (obs !== {1'b0, 1'b1, 6'd24, 4'd8, 4'd8, 3'b100}) begin
         bad++; $display("FAIL yes_final act=%h req=%h", obs, {1'b0, 1'b1, 6'd24, 4'd8, 4'd8, 3'b100});
      end
      beat(5'b01000);
      beat(5'b00110);
      total++;
      if (obs !== {1'b0, 1'b1, 6'd24, 4'd8, 4'd8, 3'b100}) begin
         bad++; $display("FAIL done_ignores_beat act=%h req=%h", obs, {1'b0, 1'b1, 6'd24, 4'd8, 4'd8, 3'b100});
      end
   endtask

   task automatic test_tie();
      do_start();
      for (int i = 0; i < 4; i++) beat(5'b00100);
      for (int i = 0; i < 4; i++) beat(5'b00010);
      total++;
      if (obs !== {1'b0, 1'b1, 6'd12, 4'd8, 4'd0, 3'b010}) begin
         bad++; $display("FAIL tie_final act=%h req=%h", obs, {1'b0, 1'b1, 6'd12, 4'd8, 4'd0, 3'b010});
      end
      do_start();
      for (int i = 0; i < 8; i++) beat(5'b00001);
      total++;
      if (obs !== {1'b0, 1'b1, 6'd0, 4'd8, 4'd8, 3'b000}) begin
         bad++; $display("FAIL all_no_final act=%h req=%h", obs, {1'b0, 1'b1, 6'd0, 4'd8, 4'd8, 3'b000});
      end
   endtask

   task automatic test_illegal();
      do_start();
      beat(5'b00100);
      beat(5'b00100);
      beat(5'b00110);
      total++;
      if (obs !== {1'b1, 1'b0, 6'd4, 4'd2, 4'd0, 3'b001}) begin
         bad++; $display("FAIL illegal_two_hot act=%h req=%h", obs, {1'b1, 1'b0, 6'd4, 4'd2, 4'd0, 3'b001});
      end
      beat(5'b10001);
      total++;
      if (obs !== {1'b1, 1'b0, 6'd4, 4'd2, 4'd0, 3'b001}) begin
         bad++; $display("FAIL illegal_bit4 act=%h req=%h", obs, {1'b1, 1'b0, 6'd4, 4'd2, 4'd0, 3'b001});
      end
      beat(5'b00000);
      tick();
      total++;
      if (obs !== {1'b1, 1'b0, 6'd4, 4'd2, 4'd0, 3'b001}) begin
         bad++; $display("FAIL illegal_zero_sticky act=%h req=%h", obs, {1'b1, 1'b0, 6'd4, 4'd2, 4'd0, 3'b001});
      end
      do_start();
      total++;
      if (obs !== {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000}) begin
         bad++; $display("FAIL start_clears_err act=%h req=%h", obs, {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000});
      end
   endtask

   task automatic test_restart();
      do_start();
      for (int i = 0; i < 3; i++) beat(5'b01000);
      total++;
      if (obs !== {1'b1, 1'b0, 6'd9, 4'd3, 4'd3, 3'b000}) begin
         bad++; $display("FAIL restart_pre act=%h req=%h", obs, {1'b1, 1'b0, 6'd9, 4'd3, 4'd3, 3'b000});
      end
      start = 1'b1;
      beat(5'b01000);
      start = 1'b0;
      total++;
      if (obs !== {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000}) begin
         bad++; $display("FAIL restart_with_beat act=%h req=%h", obs, {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000});
      end
      beat(5'b01000);
      beat(5'b01000);
      total++;
      if (obs !== {1'b1, 1'b0, 6'd6, 4'd2, 4'd2, 3'b000}) begin
         bad++; $display("FAIL restart_continue act=%h req=%h", obs, {1'b1, 1'b0, 6'd6, 4'd2, 4'd2, 3'b000});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (obs !== 19'd0) begin
         bad++; $display("FAIL abort_reset act=%h req=%h", obs, 19'd0);
      end
      do_start();
      beat(5'b00100);
      total++;
      if (obs !== {1'b1, 1'b0, 6'd2, 4'd1, 4'd0, 3'b000}) begin
         bad++; $display("FAIL after_abort act=%h req=%h", obs, {1'b1, 1'b0, 6'd2, 4'd1, 4'd0, 3'b000});
      end
   endtask

   task automatic test_start_on_final();
      do_start();
      for (int i = 0; i < 7; i++) beat(5'b00010);
      start = 1'b1;
      beat(5'b00010);
      start = 1'b0;
      total++;
      if (obs !== {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000}) begin
         bad++; $display("FAIL start_on_final act=%h req=%h", obs, {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 3'b000});
      end
   endtask

   initial begin
      test_reset();
      test_low_session();
      test_unanimous_yes();
      test_tie();
      test_illegal();
      test_restart();
      test_start_on_final();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
